// File: rtl/ir_letter_queue.sv
// Circular letter queue between the enigma encoder and the IR transmitter.
// Captures one letter per rising edge of the encoder valid and hands letters out over a busy handshake.
module ir_letter_queue #(
    parameter int DATA_WIDTH   = 5,
    parameter int DEPTH        = 1024,
    parameter int PTR_WIDTH    = $clog2(DEPTH),
    parameter int READ_LATENCY = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  data_valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  tx_busy_in,
    output logic                  tx_valid_out,
    output logic [DATA_WIDTH-1:0] tx_data_out,
    output logic [PTR_WIDTH:0]    count_out,
    output logic                  empty_out,
    output logic                  full_out,
    output logic                  overflow_out
);

    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                state, next_state;
    logic                  prev_valid;
    logic                  edge_armed;
    logic                  push, accept_push, pop;
    logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr, rd_addr;
    logic [PTR_WIDTH:0]    count_next;
    logic [LAT_W-1:0]      lat_cnt;
    logic [TMR_W-1:0]      timer;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_pipe [READ_LATENCY];

    // A valid that is already high when reset releases must drop once before it can push.
    assign push        = data_valid_in & ~prev_valid & edge_armed;
    assign accept_push = push & ~full_out;
    assign pop         = (state == WAIT_DONE) & ~tx_busy_in;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        next_state   = state;
        tx_valid_out = 1'b0;
        case (state)
            IDLE:      if (!empty_out && !tx_busy_in) next_state = FETCH;
            FETCH:     if (lat_cnt == LAT_W'(READ_LATENCY)) next_state = SEND;
            SEND: begin
                tx_valid_out = 1'b1;
                next_state   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy_in)                                next_state = WAIT_DONE;
                else if (timer == TMR_W'(BUSY_TIMEOUT - 1))    next_state = SEND;
            end
            WAIT_DONE: if (!tx_busy_in) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        count_next = count_out;
        if (accept_push && !pop)      count_next = count_out + 1'b1;
        else if (!accept_push && pop) count_next = count_out - 1'b1;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            prev_valid   <= 1'b0;
            edge_armed   <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_addr      <= '0;
            count_out    <= '0;
            empty_out    <= 1'b1;
            full_out     <= 1'b0;
            overflow_out <= 1'b0;
            lat_cnt      <= '0;
            timer        <= '0;
            tx_data_out  <= '0;
        end else begin
            state      <= next_state;
            prev_valid <= data_valid_in;
            edge_armed <= edge_armed | ~data_valid_in;

            if (accept_push)           wr_ptr       <= wr_ptr + 1'b1;
            if (push && full_out)      overflow_out <= 1'b1;
            if (pop)                   rd_ptr       <= rd_ptr + 1'b1;

            count_out <= count_next;
            empty_out <= (count_next == '0);
            full_out  <= (count_next == (PTR_WIDTH + 1)'(DEPTH));

            if (state == IDLE && next_state == FETCH) rd_addr <= rd_ptr;

            lat_cnt <= (state == FETCH && next_state == FETCH) ? lat_cnt + 1'b1 : '0;
            timer   <= (state == WAIT_BUSY && next_state == WAIT_BUSY) ? timer + 1'b1 : '0;

            if (state == FETCH && next_state == SEND) tx_data_out <= rd_pipe[READ_LATENCY-1];
        end
    end

    // NOTE: the letter store and its read pipeline are deliberately left out of reset so they map to block RAM.
    always_ff @(posedge clk_in) begin
        if (accept_push) mem[wr_ptr] <= data_in;
        rd_pipe[0] <= mem[rd_addr];
        for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

endmodule

// File: tb/tb_ir_letter_queue.sv
// Scoreboard bench for ir_letter_queue: default-depth and DEPTH=4 instances share one clock and reset.
// Stimulus queues expected letters; one monitor process compares every tx_valid_out pulse.
`timescale 1ns/1ps
module tb_ir_letter_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        dv, busy, dv4, busy4;
    logic [4:0]  din, din4;
    logic        tx_valid, tx_valid4;
    logic [4:0]  tx_data, tx_data4;
    logic [10:0] count;
    logic [2:0]  count4;
    logic        empty, full, ovf, empty4, full4, ovf4;

    int n_cmp = 0;
    int n_bad = 0;
    logic [4:0] exp_q  [$];
    logic [4:0] exp_q4 [$];

    always #5 clk = ~clk;

    ir_letter_queue dut (
        .clk_in(clk), .rst_in(rst), .data_valid_in(dv), .data_in(din), .tx_busy_in(busy),
        .tx_valid_out(tx_valid), .tx_data_out(tx_data), .count_out(count),
        .empty_out(empty), .full_out(full), .overflow_out(ovf)
    );

    ir_letter_queue #(.DEPTH(4)) dut4 (
        .clk_in(clk), .rst_in(rst), .data_valid_in(dv4), .data_in(din4), .tx_busy_in(busy4),
        .tx_valid_out(tx_valid4), .tx_data_out(tx_data4), .count_out(count4),
        .empty_out(empty4), .full_out(full4), .overflow_out(ovf4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Monitor: every pulse from either instance must match the head of its expected queue.
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (tx_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_main: unexpected pulse with letter %0d", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        n_bad++;
                        $display("FAIL sb_main: got letter %0d, expected %0d", tx_data, e);
                    end
                end
            end
            if (tx_valid4) begin
                n_cmp++;
                if (exp_q4.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_depth4: unexpected pulse with letter %0d", tx_data4);
                end else begin
                    e = exp_q4.pop_front();
                    if (tx_data4 !== e) begin
                        n_bad++;
                        $display("FAIL sb_depth4: got letter %0d, expected %0d", tx_data4, e);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic sel_valid(input bit which);
        return which ? tx_valid4 : tx_valid;
    endfunction

    // Counts negedges until the selected instance pulses; an expired bound is a failed comparison.
    task automatic wait_pulse(input bit which, input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!sel_valid(which) && cyc < limit);
        if (!sel_valid(which)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pulse_timeout: no tx_valid_out within %0d cycles (dut%0d)", limit, which ? 4 : 0);
        end
    endtask

    task automatic push_letter(input bit which, input logic [4:0] letter);
        if (which) begin dv4 = 1'b1; din4 = letter; end
        else       begin dv  = 1'b1; din  = letter; end
        @(negedge clk);
        if (which) dv4 = 1'b0; else dv = 1'b0;
        @(negedge clk);
    endtask

    task automatic handshake(input bit which, input int busy_len);
        int cyc;
        wait_pulse(which, 100, cyc);
        if (which) busy4 = 1'b1; else busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        if (which) busy4 = 1'b0; else busy = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; dv = 1'b0; din = '0; busy = 1'b0;
        dv4 = 1'b0; din4 = '0; busy4 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data",  tx_data,  0);
        check("rst_count",    count,    0);
        check("rst_empty",    empty,    1);
        check("rst_full",     full,     0);
        check("rst_overflow", ovf,      0);
        check("rst_empty4",   empty4,   1);

        // 1: single letter, latency and busy handshake
        exp_q.push_back(5'd7);
        dv = 1'b1; din = 5'd7;
        wait_pulse(0, 20, cyc);
        check("t1_latency", cyc, 5);
        busy = 1'b1; dv = 1'b0;
        repeat (50) @(negedge clk);
        check("t1_count_inflight", count, 1);
        repeat (50) @(negedge clk);
        busy = 1'b0;
        repeat (2) @(negedge clk);
        check("t1_count_done", count, 0);
        check("t1_empty_done", empty, 1);

        // 2: three letters queued behind a busy transmitter
        busy = 1'b1;
        exp_q.push_back(5'd3); push_letter(0, 5'd3);
        exp_q.push_back(5'd1); push_letter(0, 5'd1);
        exp_q.push_back(5'd4); push_letter(0, 5'd4);
        check("t2_count", count, 3);
        check("t2_empty", empty, 0);
        busy = 1'b0;
        repeat (3) handshake(0, 10);
        check("t2_count_done", count, 0);

        // 3: level-held valid writes once
        busy = 1'b1;
        exp_q.push_back(5'd22);
        dv = 1'b1; din = 5'd22;
        repeat (50) @(negedge clk);
        dv = 1'b0;
        @(negedge clk);
        check("t3_count", count, 1);
        busy = 1'b0;
        handshake(0, 5);
        check("t3_count_done", count, 0);

        // 4: DEPTH=4 overflow, fifth letter dropped
        busy4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q4.push_back(5'(10 + i));
            push_letter(1, 5'(10 + i));
        end
        check("t4_count",    count4, 4);
        check("t4_full",     full4,  1);
        check("t4_overflow", ovf4,   1);
        busy4 = 1'b0;
        repeat (4) handshake(1, 4);
        repeat (30) @(negedge clk);
        check("t4_count_done", count4, 0);
        check("t4_empty_done", empty4, 1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t4_overflow_cleared", ovf4, 0);

        // 5: DEPTH=4 wraparound, ten letters in pairs
        for (int i = 0; i < 5; i++) begin
            exp_q4.push_back(5'(2 * i + 1));  push_letter(1, 5'(2 * i + 1));
            exp_q4.push_back(5'(2 * i + 16)); push_letter(1, 5'(2 * i + 16));
            repeat (2) handshake(1, 3);
        end
        check("t5_overflow", ovf4,   0);
        check("t5_count",    count4, 0);

        // 6: busy never rises -> re-pulse; then reset while waiting for busy to drop
        repeat (3) exp_q.push_back(5'd9);
        dv = 1'b1; din = 5'd9;
        @(negedge clk); dv = 1'b0;
        @(negedge clk); dv = 1'b1; din = 5'd5;
        @(negedge clk); dv = 1'b0;
        check("t6_count", count, 2);
        wait_pulse(0, 20, cyc);
        wait_pulse(0, 40, cyc);
        check("t6_repulse_period1", cyc, 17);
        wait_pulse(0, 40, cyc);
        check("t6_repulse_period2", cyc, 17);
        busy = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1; dv = 1'b1; din = 5'd12;
        @(negedge clk);
        check("t6_rst_tx_valid", tx_valid, 0);
        check("t6_rst_tx_data",  tx_data,  0);
        check("t6_rst_count",    count,    0);
        check("t6_rst_empty",    empty,    1);
        check("t6_rst_full",     full,     0);
        check("t6_rst_overflow", ovf,      0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_held_valid_no_push", count, 0);
        dv = 1'b0; busy = 1'b0;
        repeat (30) @(negedge clk);
        check("t6_idle_count", count, 0);
        check("t6_idle_empty", empty, 1);

        check("sb_main_drained",   exp_q.size(),  0);
        check("sb_depth4_drained", exp_q4.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
